// File: rtl/seq_divider8_pkg.sv
// Shared types and widths for the 8-bit sequential restoring divider.
package div_pkg;
    localparam int DIV_W  = 8;
    localparam int ITER_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;
endpackage

// File: rtl/seq_divider8_sub9.sv
// 9-bit ripple subtractor (a - b) built from full_adder cells: b inverted, carry-in 1.
// cout = 1 means no borrow, i.e. a >= b.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module sub9
    import div_pkg::*;
(
    input  logic [DIV_W:0] i_a,
    input  logic [DIV_W:0] i_b,
    output logic [DIV_W:0] difference,
    output logic           cout
);
    logic [DIV_W+1:0] w_c;

    assign w_c[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi <= DIV_W; gi++) begin : g_fa
            full_adder u_fa (
                .a    (i_a[gi]),
                .b    (~i_b[gi]),
                .cin  (w_c[gi]),
                .s    (difference[gi]),
                .cout (w_c[gi+1])
            );
        end
    endgenerate

    assign cout = w_c[DIV_W+1];
endmodule

// File: rtl/seq_divider8.sv
// 8-bit unsigned restoring divider: one quotient bit per ITER cycle, results
// published only on the edge that enters DONE.
module seq_divider8
    import div_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [DIV_W-1:0] Dividend,
    input  logic [DIV_W-1:0] Divisor,
    output logic [DIV_W-1:0] Quotient,
    output logic [DIV_W-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);
    state_t              r_state, w_state_next;
    logic [ITER_W-1:0]   r_cnt;
    logic [DIV_W-1:0]    r_q, r_r, r_d;
    logic [DIV_W-1:0]    r_quot, r_rem;
    logic                r_dbz;
    logic [DIV_W:0]      w_p, w_diff;
    logic                w_cout, w_last;
    logic [DIV_W-1:0]    w_q_step, w_r_step;

    // Trial value: partial remainder shifted left with the next dividend bit.
    assign w_p = {r_r, r_q[DIV_W-1]};

    sub9 u_sub9 (
        .i_a        (w_p),
        .i_b        ({1'b0, r_d}),
        .difference (w_diff),
        .cout       (w_cout)
    );

    assign w_r_step = w_cout ? w_diff[DIV_W-1:0] : w_p[DIV_W-1:0];
    assign w_q_step = {r_q[DIV_W-2:0], w_cout};
    assign w_last   = (r_cnt == '1);

    always_comb begin
        w_state_next = r_state;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start)
                    w_state_next = (Divisor == '0) ? DONE : ITER;
            end
            ITER: begin
                Busy = 1'b1;
                if (w_last)
                    w_state_next = DONE;
            end
            DONE: begin
                Done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_d    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_q   <= Dividend;
                        r_d   <= Divisor;
                        r_r   <= '0;
                        r_cnt <= '0;
                        if (Divisor == '0) begin
                            r_quot <= '1;
                            r_rem  <= Dividend;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    r_q   <= w_q_step;
                    r_r   <= w_r_step;
                    r_cnt <= r_cnt + ITER_W'(1);
                    if (w_last) begin
                        r_quot <= w_q_step;
                        r_rem  <= w_r_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign DivByZero = r_dbz;
endmodule

// File: tb/tb_seq_divider8.sv
// Scenario bench for seq_divider8: expected results are queued at issue time
// and compared when Done pulses.
module tb_seq_divider8;
    logic       Clk, Reset_n, Start;
    logic [7:0] Dividend, Divisor, Quotient, Remainder;
    logic       Busy, Done, DivByZero;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] prev_q = 8'h00;

    seq_divider8 dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Waits for Done (edges counted from the Start-sampling edge = 1), then checks.
    task automatic wait_done(input int edges_in, input int exp_lat, input string name);
        int   edges = edges_in;
        exp_t e;
        while (Done !== 1'b1 && edges < 20) begin
            total++;
            if (Quotient !== prev_q) begin
                bad++;
                $display("FAIL %s hold: Quotient=%0d during op, required %0d", name, Quotient, prev_q);
            end
            @(posedge Clk); edges++; #1;
        end
        total++;
        if (Done !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: Done=%b after %0d edges, required 1", name, Done, edges);
        end
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: queue empty, required one entry", name);
            return;
        end
        e = sb.pop_front();
        total++;
        if (Quotient !== e.q) begin
            bad++;
            $display("FAIL %s quotient: got %0d, required %0d", name, Quotient, e.q);
        end
        total++;
        if (Remainder !== e.r) begin
            bad++;
            $display("FAIL %s remainder: got %0d, required %0d", name, Remainder, e.r);
        end
        total++;
        if (DivByZero !== e.dbz) begin
            bad++;
            $display("FAIL %s divbyzero: got %b, required %b", name, DivByZero, e.dbz);
        end
        total++;
        if (edges != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, edges, exp_lat);
        end
        prev_q = e.q;
        @(posedge Clk); #1;
        total++;
        if ({Done, Busy} !== 2'b00) begin
            bad++;
            $display("FAIL %s pulse: Done,Busy=%b%b after DONE, required 00", name, Done, Busy);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input int lat, input string name);
        @(negedge Clk);
        Start = 1'b1; Dividend = a; Divisor = b;
        sb.push_back(model(a, b));
        @(posedge Clk); #1;
        Start = 1'b0;
        Dividend = 8'($urandom);
        Divisor  = 8'($urandom);
        wait_done(1, lat, name);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== 19'd0) begin
            bad++;
            $display("FAIL reset_async: Q=%0d R=%0d B=%b D=%b Z=%b, required all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        @(negedge Clk); @(negedge Clk);
        total++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== 19'd0) begin
            bad++;
            $display("FAIL reset_held: Q=%0d R=%0d B=%b D=%b Z=%b, required all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_basic();
        issue(8'd100, 8'd7,   9, "100/7");
        issue(8'd255, 8'd1,   9, "255/1");
        issue(8'd255, 8'd255, 9, "255/255");
        issue(8'd5,   8'd9,   9, "5/9");
        issue(8'd0,   8'd3,   9, "0/3");
    endtask

    task automatic test_div_zero();
        issue(8'd200, 8'd0, 1, "200/0");
        issue(8'd9,   8'd3, 9, "9/3_after_dbz");
    endtask

    task automatic test_start_held();
        int edges;
        @(negedge Clk);
        Start = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
        sb.push_back(model(8'd100, 8'd7));
        @(posedge Clk); #1;
        edges = 1;
        repeat (3) begin
            @(posedge Clk); edges++; #1;
        end
        total++;
        if (Busy !== 1'b1) begin
            bad++;
            $display("FAIL held busy: Busy=%b mid-op, required 1", Busy);
        end
        Dividend = 8'd50; Divisor = 8'd5;
        wait_done(edges, 9, "held_100/7");
        sb.push_back(model(8'd50, 8'd5));
        @(posedge Clk); #1;
        Start = 1'b0;
        total++;
        if (Busy !== 1'b1) begin
            bad++;
            $display("FAIL held reaccept: Busy=%b after IDLE edge, required 1", Busy);
        end
        wait_done(1, 9, "held_50/5");
    endtask

    task automatic test_reset_mid_iter();
        int done_seen = 0;
        @(negedge Clk);
        Start = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        total++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== 19'd0) begin
            bad++;
            $display("FAIL rst_mid immediate: Q=%0d R=%0d B=%b D=%b Z=%b, required all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        repeat (10) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL rst_mid no_done: saw %0d Done cycles, required 0", done_seen);
        end
        prev_q = 8'h00;
        @(negedge Clk);
        Reset_n = 1'b1;
        Start = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
        sb.push_back(model(8'd100, 8'd7));
        @(posedge Clk); #1;
        Start = 1'b0;
        total++;
        if (Busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid first_start: Busy=%b, required 1", Busy);
        end
        wait_done(1, 9, "rst_rerun_100/7");
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            issue(a, b, 9, "random");
        end
    endtask

    initial begin
        Reset_n  = 1'b0;
        Start    = 1'b0;
        Dividend = 8'd0;
        Divisor  = 8'd0;
        test_reset();
        test_basic();
        test_div_zero();
        test_start_held();
        test_reset_mid_iter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
